barrel_shifter_right_pipe: RTL

Four-stage pipelined 16-bit right barrel shifter with a valid/ready handshake on both sides. It supports logical, arithmetic and rotate-right modes. It is the right-direction companion to the combinational left barrel shifter in the lab_4 shifter set. Each pipeline stage resolves one bit of the shift magnitude, so the block sustains one operation per clock at the cost of 4 cycles of latency.

---
 rtl/barrel_shifter_right_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/barrel_shifter_right_pipe.sv
// Four-stage pipelined 16-bit right barrel shifter (logical / arithmetic / rotate).
// Each stage resolves one shift_mag bit; valid/ready on both sides with bubble collapsing.
module barrel_shifter_right_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] Ip,
    input  logic [3:0]  shift_mag,
    input  logic [1:0]  mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Op
);

    localparam int unsigned W    = 16;
    localparam int unsigned MODE = 2;

    // One fixed-distance right shift; upper fill chosen by mode (reserved acts as logical).
    function automatic logic [W-1:0] shr_stage(
        input logic [W-1:0]    d,
        input logic            sign,
        input logic [MODE-1:0] md,
        input logic            en,
        input int unsigned     sh
    );
        logic [W-1:0] fill;
        fill = '0;
        case (md)
            2'b01:   fill = {W{sign}};
            2'b10:   fill = d;
            default: fill = '0;
        endcase
        if (!en) return d;
        return W'({fill, d} >> sh);
    endfunction

    logic [W-1:0]    s1_data, s2_data, s3_data, s4_data;
    logic [2:0]      s1_mag;
    logic [1:0]      s2_mag;
    logic            s3_mag;
    logic [MODE-1:0] s1_mode, s2_mode, s3_mode;
    logic            s1_sign, s2_sign, s3_sign;
    logic            s1_v, s2_v, s3_v, s4_v;
    logic            ld1, ld2, ld3, ld4;

    // Load enables ripple back from the output so bubbles are squeezed out.
    assign ld4      = !s4_v || out_ready;
    assign ld3      = !s3_v || ld4;
    assign ld2      = !s2_v || ld3;
    assign ld1      = !s1_v || ld2;
    assign in_ready = ld1;

    assign Op        = s4_data;
    assign out_valid = s4_v;

    // Payload only moves with a valid token; valid flags follow the load enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data <= '0; s2_data <= '0; s3_data <= '0; s4_data <= '0;
            s1_mag  <= '0; s2_mag  <= '0; s3_mag  <= 1'b0;
            s1_mode <= '0; s2_mode <= '0; s3_mode <= '0;
            s1_sign <= 1'b0; s2_sign <= 1'b0; s3_sign <= 1'b0;
            s1_v    <= 1'b0; s2_v    <= 1'b0; s3_v    <= 1'b0; s4_v <= 1'b0;
        end else begin
            if (ld1) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_data <= shr_stage(Ip, Ip[15], mode, shift_mag[0], 32'd1);
                    s1_mag  <= shift_mag[3:1];
                    s1_mode <= mode;
                    s1_sign <= Ip[15];
                end
            end
            if (ld2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_data <= shr_stage(s1_data, s1_sign, s1_mode, s1_mag[0], 32'd2);
                    s2_mag  <= s1_mag[2:1];
                    s2_mode <= s1_mode;
                    s2_sign <= s1_sign;
                end
            end
            if (ld3) begin
                s3_v <= s2_v;
                if (s2_v) begin
                    s3_data <= shr_stage(s2_data, s2_sign, s2_mode, s2_mag[0], 32'd4);
                    s3_mag  <= s2_mag[1];
                    s3_mode <= s2_mode;
                    s3_sign <= s2_sign;
                end
            end
            if (ld4) begin
                s4_v <= s3_v;
                if (s3_v) begin
                    s4_data <= shr_stage(s3_data, s3_sign, s3_mode, s3_mag, 32'd8);
                end
            end
        end
    end

endmodule
